// File: rtl/agc_dsky_pkg.sv
// Shared types and constants for the DSKY relay-word display sequencer.
package agc_dsky_pkg;

  localparam int NUM_POS  = 22;
  localparam int NUM_ROWS = 11;

  typedef logic [4:0] dsky_code_t;

  localparam dsky_code_t CODE_BLANK = 5'd0;
  localparam dsky_code_t CODE_0     = 5'd21;
  localparam dsky_code_t CODE_1     = 5'd3;
  localparam dsky_code_t CODE_2     = 5'd25;
  localparam dsky_code_t CODE_3     = 5'd27;
  localparam dsky_code_t CODE_4     = 5'd15;
  localparam dsky_code_t CODE_5     = 5'd30;
  localparam dsky_code_t CODE_6     = 5'd28;
  localparam dsky_code_t CODE_7     = 5'd19;
  localparam dsky_code_t CODE_8     = 5'd29;
  localparam dsky_code_t CODE_9     = 5'd31;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW,
    ST_GAP
  } state_t;

endpackage

// File: rtl/agc_dsky_decode.sv
// DSKY 5-bit relay code to seven-segment pattern; unknown codes show a dash.
module agc_dsky_decode
  import agc_dsky_pkg::*;
(
  input  dsky_code_t code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (code)
      CODE_BLANK: seg = SEG_BLANK;
      CODE_0:     seg = SEG_0;
      CODE_1:     seg = SEG_1;
      CODE_2:     seg = SEG_2;
      CODE_3:     seg = SEG_3;
      CODE_4:     seg = SEG_4;
      CODE_5:     seg = SEG_5;
      CODE_6:     seg = SEG_6;
      CODE_7:     seg = SEG_7;
      CODE_8:     seg = SEG_8;
      CODE_9:     seg = SEG_9;
      default:    seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/agc_dsky_scan.sv
// Captures DSKY relay words into a 22-digit store and multiplexes the
// non-blank digits onto one seven-segment display.
//
// state   | meaning
// ST_IDLE | store entirely blank, display dark
// ST_SHOW | digit_idx shown for DWELL_CYCLES cycles
// ST_GAP  | display blanked for GAP_CYCLES cycles before advancing
module agc_dsky_scan
  import agc_dsky_pkg::*;
#(
  parameter int DWELL_CYCLES = 1_000_000,
  parameter int GAP_CYCLES   = 250_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [14:0] wr_data,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [4:0]  digit_idx,
  output logic        frame_start
);

  localparam int MAX_CYC = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  dsky_code_t          codes [NUM_POS];
  logic [NUM_ROWS-1:0] signs;
  logic [14:0]         hold_data;
  logic [3:0]          hold_row;
  logic [3:0]          row_m1;
  logic                row_ok;

  assign hold_row = hold_data[14:11];
  assign row_m1   = hold_row - 4'd1;
  assign row_ok   = (hold_row >= 4'd1) && (hold_row <= 4'd11);

  // wr_ready low means the holding register is occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ready  <= 1'b1;
      hold_data <= '0;
      signs     <= '0;
      for (int i = 0; i < NUM_POS; i++) codes[5'(i)] <= CODE_BLANK;
    end else if (!wr_ready) begin
      if (row_ok) begin
        codes[{row_m1, 1'b0}] <= hold_data[9:5];
        codes[{row_m1, 1'b1}] <= hold_data[4:0];
        signs[row_m1]         <= hold_data[10];
      end
      wr_ready <= 1'b1;
    end else if (wr_valid) begin
      hold_data <= wr_data;
      wr_ready  <= 1'b0;
    end
  end

  logic       any_set;
  logic [4:0] low_idx;
  logic [4:0] nxt_idx;

  always_comb begin : low_search
    any_set = 1'b0;
    low_idx = '0;
    for (int i = NUM_POS - 1; i >= 0; i--) begin
      if (codes[5'(i)] != CODE_BLANK) begin
        any_set = 1'b1;
        low_idx = 5'(i);
      end
    end
  end

  // First non-blank after digit_idx, wrapping; k = NUM_POS lands on itself.
  always_comb begin : nxt_search
    int  p;
    logic found;
    p       = 0;
    found   = 1'b0;
    nxt_idx = '0;
    for (int k = 1; k <= NUM_POS; k++) begin
      p = (int'(digit_idx) + k) % NUM_POS;
      if (!found && codes[5'(p)] != CODE_BLANK) begin
        found   = 1'b1;
        nxt_idx = 5'(p);
      end
    end
  end

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            cnt_done;
  logic            advance;
  logic [4:0]      sel_idx;
  logic [6:0]      sel_seg;
  logic            sel_dp;

  assign cnt_done = (cnt == '0);
  assign advance  = cnt_done &&
                    ((state == ST_GAP) || (state == ST_SHOW && GAP_CYCLES == 0));

  always_comb begin
    sel_idx = digit_idx;
    if (state == ST_IDLE) sel_idx = low_idx;
    else if (advance)     sel_idx = nxt_idx;
  end

  agc_dsky_decode u_decode (
    .code (codes[sel_idx]),
    .seg  (sel_seg)
  );

  assign sel_dp = ~sel_idx[0] & signs[sel_idx[4:1]];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      seg         <= SEG_BLANK;
      dp          <= 1'b0;
      digit_idx   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (advance) begin
        if (any_set) begin
          state       <= ST_SHOW;
          cnt         <= DWELL_LOAD;
          digit_idx   <= sel_idx;
          seg         <= sel_seg;
          dp          <= sel_dp;
          frame_start <= (sel_idx <= digit_idx);
        end else begin
          state     <= ST_IDLE;
          cnt       <= '0;
          digit_idx <= '0;
          seg       <= SEG_BLANK;
          dp        <= 1'b0;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (any_set) begin
              state       <= ST_SHOW;
              cnt         <= DWELL_LOAD;
              digit_idx   <= sel_idx;
              seg         <= sel_seg;
              dp          <= sel_dp;
              frame_start <= 1'b1;
            end
          end
          ST_SHOW: begin
            if (!cnt_done) begin
              cnt <= cnt - 1'b1;
              seg <= sel_seg;
              dp  <= sel_dp;
            end else begin
              state <= ST_GAP;
              cnt   <= GAP_LOAD;
              seg   <= SEG_BLANK;
              dp    <= 1'b0;
            end
          end
          ST_GAP: begin
            cnt <= cnt - 1'b1;
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_agc_dsky_scan.sv
// Scoreboard bench for agc_dsky_scan: a timeline reference model predicts
// every cycle's outputs, a negedge monitor pops and compares.
module tb_agc_dsky_scan;

  localparam int D = 4;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [14:0] wr_data = '0;
  logic        wr_ready;
  logic [6:0]  seg;
  logic        dp;
  logic [4:0]  digit_idx;
  logic        frame_start;

  agc_dsky_scan #(.DWELL_CYCLES(D), .GAP_CYCLES(G)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .seg         (seg),
    .dp          (dp),
    .digit_idx   (digit_idx),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy;
    logic [6:0] seg;
    logic       dp;
    logic [4:0] idx;
    logic       fs;
  } obs_t;

  obs_t  exp_q[$];
  int    total = 0;
  int    bad = 0;
  string phase = "reset";

  int          m_code [22];
  bit          m_sign [11];
  bit          m_hold;
  logic [14:0] m_hdata;
  bit          m_active;
  int          m_pos;
  int          m_age;

  function automatic logic [6:0] ref_seg(input int c);
    case (c)
      0:       return 7'h00;
      21:      return 7'h3F;
      3:       return 7'h06;
      25:      return 7'h5B;
      27:      return 7'h4F;
      15:      return 7'h66;
      30:      return 7'h6D;
      28:      return 7'h7D;
      19:      return 7'h07;
      29:      return 7'h7F;
      31:      return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic int next_nb(input int from);
    for (int k = 1; k <= 22; k++) begin
      int p;
      p = (from + k) % 22;
      if (m_code[p] != 0) return p;
    end
    return -1;
  endfunction

  // Model: a digit lives for D+G cycles counted by m_age; display decisions
  // use the store as it was before this edge, then the write path updates it.
  always @(posedge clk) begin
    obs_t o;
    int   p;
    int   row;
    bit   show;
    o    = '0;
    show = 1'b0;
    if (rst) begin
      foreach (m_code[i]) m_code[i] = 0;
      foreach (m_sign[i]) m_sign[i] = 1'b0;
      m_hold   = 1'b0;
      m_active = 1'b0;
      m_pos    = 0;
      m_age    = 0;
      o.rdy    = 1'b1;
    end else begin
      if (!m_active) begin
        p = next_nb(21);
        if (p >= 0) begin
          m_active = 1'b1;
          m_pos    = p;
          m_age    = 0;
          o.fs     = 1'b1;
          show     = 1'b1;
        end
      end else begin
        m_age++;
        if (m_age < D) show = 1'b1;
        else if (m_age < D + G) show = 1'b0;
        else begin
          p = next_nb(m_pos);
          if (p < 0) begin
            m_active = 1'b0;
            m_pos    = 0;
          end else begin
            o.fs  = (p <= m_pos);
            m_pos = p;
            m_age = 0;
            show  = 1'b1;
          end
        end
      end
      if (m_active && show) begin
        o.seg = ref_seg(m_code[m_pos]);
        o.dp  = (m_pos % 2 == 0) ? m_sign[m_pos / 2] : 1'b0;
      end
      o.idx = 5'(m_pos);
      if (m_hold) begin
        row = int'(m_hdata[14:11]);
        if (row >= 1 && row <= 11) begin
          m_code[2 * (row - 1)] = int'(m_hdata[9:5]);
          m_code[2 * row - 1]   = int'(m_hdata[4:0]);
          m_sign[row - 1]       = m_hdata[10];
        end
        m_hold = 1'b0;
      end else if (wr_valid) begin
        m_hold  = 1'b1;
        m_hdata = wr_data;
      end
      o.rdy = !m_hold;
    end
    exp_q.push_back(o);
  end

  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {wr_ready, seg, dp, digit_idx, frame_start};
      total++;
      if (a !== e) begin
        bad++;
        if (bad <= 30)
          $display("FAIL %s @%0t: got rdy=%b seg=%h dp=%b idx=%0d fs=%b, want rdy=%b seg=%h dp=%b idx=%0d fs=%b",
                   phase, $time, a.rdy, a.seg, a.dp, a.idx, a.fs, e.rdy, e.seg, e.dp, e.idx, e.fs);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [14:0] word(input int row, input bit s, input int l, input int r);
    return {4'(row), s, 5'(l), 5'(r)};
  endfunction

  function automatic int rnd_code();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 5) return 0;
    if (r < 9) begin
      case ($urandom_range(0, 9))
        0: return 21;  1: return 3;   2: return 25;  3: return 27;  4: return 15;
        5: return 30;  6: return 28;  7: return 19;  8: return 29;  default: return 31;
      endcase
    end
    return int'($urandom_range(0, 31));
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!wr_ready && n < 10) begin
      cyc(1);
      n++;
    end
    if (!wr_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: wr_ready=%b want 1", wr_ready);
    end
  endtask

  task automatic send(input logic [14:0] w);
    wait_ready();
    wr_valid = 1'b1;
    wr_data  = w;
    cyc(1);
    wr_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(10);

    phase = "single";
    send(word(1, 1'b1, 21, 0));
    cyc(30);

    phase = "blank_row";
    send(word(1, 1'b0, 0, 0));
    cyc(15);

    phase = "skip_wrap";
    send(word(2, 1'b0, 3, 31));
    send(word(11, 1'b0, 0, 25));
    cyc(60);

    phase = "invalid";
    send(word(3, 1'b1, 7, 0));
    send(word(13, 1'b1, 29, 29));
    send(word(0, 1'b0, 21, 21));
    cyc(60);

    phase = "b2b";
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = word(4 + i, 1'(i), 27, 15);
      n = 0;
      while (!wr_ready && n < 10) begin
        cyc(1);
        n++;
      end
      cyc(1);
    end
    wr_valid = 1'b0;
    cyc(80);

    phase = "blank_mid";
    send(word(2, 1'b0, 0, 0));
    send(word(3, 1'b0, 0, 0));
    cyc(7);
    send(word(4, 1'b0, 0, 0));
    send(word(5, 1'b0, 0, 0));
    send(word(6, 1'b0, 0, 0));
    cyc(9);
    send(word(11, 1'b0, 0, 0));
    cyc(30);

    phase = "rst_gap";
    send(word(1, 1'b1, 29, 0));
    n = 0;
    while (!(m_active && m_age == D) && n < 100) begin
      cyc(1);
      n++;
    end
    total++;
    if (!(m_active && m_age == D)) begin
      bad++;
      $display("FAIL gap_timeout: reached_gap=0 want 1");
    end
    wr_valid = 1'b1;
    wr_data  = word(7, 1'b0, 21, 21);
    cyc(1);
    wr_valid = 1'b0;
    rst      = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(20);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_data  = word(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), rnd_code(), rnd_code());
      rst      = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    rst      = 1'b0;
    wr_valid = 1'b0;
    cyc(5);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/agc_dsky_scan.md
# agc_dsky_scan

Display sequencer downstream of the AGC core's OUT0 (channel 10) relay-word output. It captures 15-bit DSKY relay words into a 22-digit store and time-multiplexes the non-blank digits onto the single seven-segment display driven from `uo_out[7:0]` of `tt_um_cordus_wrapper_agc`. It also drives a sign indicator on the decimal point and a frame marker for the wrapper.

## Interface
- `DWELL_CYCLES`, default 1_000_000: cycles each digit is shown; must be ≥1.
- `GAP_CYCLES`, default 250_000: blank cycles between digits; 0 means no gap.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  relay word offered.
- `wr_ready`  out  1  block can accept a word.
- `wr_data`  in  15  relay word:
  - [14:11] row (1–11 valid);
  - [10] sign flag;
  - [9:5] left-digit DSKY code;
  - [4:0] right-digit DSKY code.
- `seg`  out  7  segments, active high, [0]=a … [6]=g; maps to `uo_out[6:0]`.
- `dp`  out  1  sign indicator; maps to `uo_out[7]`.
- `digit_idx`  out  5  position currently shown (0–21).
- `frame_start`  out  1  one-cycle pulse at start of each scan frame.

## Operation
- **Store**
  - 22 five-bit code entries plus 11 sign bits.
  - Position p = (row−1)·2 + (0 left, 1 right).
- **Write path**
  - Transfer occurs when `wr_valid & wr_ready`.
  - The word is latched into a one-entry holding register and `wr_ready` drops.
  - On the next edge the holding register writes the store (both codes + sign of that row) and `wr_ready` returns high.
  - Maximum rate is one word per 2 cycles.
  - Rows 0 and 12–15 are consumed and discarded; the store is unchanged.
- **Code decode (DSKY 5-bit → seg)**
  - Blank: 0 → 0x00.
  - Digits: 21→0 (0x3F), 3→1 (0x06), 25→2 (0x5B), 27→3 (0x4F), 15→4 (0x66), 30→5 (0x6D), 28→6 (0x7D), 19→7 (0x07), 29→8 (0x7F), 31→9 (0x6F).
  - Any other code → dash, 0x40.
- **State machine** (IDLE, SHOW, GAP)
  - **IDLE**: `seg`=0, `dp`=0, `digit_idx`=0. Goes to SHOW when any entry is non-blank. The shown position is the lowest non-blank index, and `frame_start` pulses.
  - **SHOW**: `seg`=decode(store[digit_idx]). `dp`=sign of the row on left positions and 0 on right positions. After DWELL_CYCLES cycles, goes to GAP (or to the advance step directly if GAP_CYCLES=0).
  - **GAP**: `seg`=0, `dp`=0, `digit_idx` held. After GAP_CYCLES cycles, performs the advance step.
- **Advance step**
  - Select the next non-blank index after `digit_idx`, wrapping 21→0; if the only non-blank entry is the current one, it re-selects itself.
  - `frame_start` pulses when the selected index ≤ current index (a wrap).
  - If no entry is non-blank, go to IDLE.
- **Live writes during SHOW**
  - Updates `seg` live, including blanking the shown digit.
  - Blank-skipping is evaluated only at the advance step.

## Timing
- **Reset**
  - Store cleared and holding register empty.
  - State IDLE, dwell/gap counters 0.
  - `wr_ready`=1, `seg`=0, `dp`=0, `digit_idx`=0, `frame_start`=0.
  - Reset mid-frame has the same effect; any pending held word is dropped.
- **Output registers**: all outputs are registered.
- **Write-to-display latency**
  - Accept on edge t; store updated on edge t+1; `seg` reflects it on edge t+2 if that position is shown.
- **Leaving IDLE**: the first store write of a non-blank code moves IDLE→SHOW on edge t+2.
- **Dwell and gap periods**: a digit occupies exactly DWELL_CYCLES cycles of SHOW, and a gap occupies exactly GAP_CYCLES cycles.
- **Frame marker**: `frame_start` is high in the first SHOW cycle of a frame.
- **Wide counters**: dwell/gap counter width is $clog2(max(DWELL_CYCLES,GAP_CYCLES)+1), with no wrap beyond the terminal count.

## Structure
- **Package `agc_dsky_pkg`**
  - `NUM_POS`=22 and `NUM_ROWS`=11.
  - Typedef for the 5-bit DSKY code.
  - Named constants for the ten digit codes and for the seg patterns (including BLANK and DASH).
  - State enum.
- **Sub-module `agc_dsky_decode`**: combinational, code → seg.
- **Top level**: store, holding register, FSM, counters, next-non-blank priority search.

## Test plan
Parameters for all scenarios: DWELL_CYCLES=4, GAP_CYCLES=2.
- **Reset values**: reset → `wr_ready`=1, `seg`=0, `dp`=0, `digit_idx`=0; stays IDLE with no writes.
- **Single digit, repeating frame**: write row 1, sign=1, left=21, right=0 → from edge t+2, `seg`=0x3F, `dp`=1, `digit_idx`=0, `frame_start` pulse. Then 4 SHOW cycles, 2 blank cycles, repeat with `frame_start` each time.
- **Blank skipping and wrap**: write row 2 (left=3, right=31) and row 11 (left=0, right=25) → scan order 2 (0x06), 3 (0x6F), 21 (0x5B), then wrap to 2 with `frame_start`. Positions 0,1,20 are never shown.
- **Invalid codes and rows**: invalid code 7 → dash 0x40. A write to row 13 or row 0 is accepted (`wr_ready` low one cycle) and leaves the store unchanged.
- **Back-to-back writes**: hold `wr_valid` high for 3 words → accepted on alternate cycles, all three stored. Blanking the displayed row mid-SHOW gives `seg`=0 within 2 cycles, then the advance skips it or goes to IDLE if none remain.
- **Reset mid-operation**: assert `rst` mid-GAP with a held word pending → all reset values next cycle; the pending word is lost; the display stays IDLE.
